// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: widths, FSM states and the
// small-sigma functions used to expand W[16..63].
package sha256_pkg;

  localparam int WORD_W          = 32;
  localparam int ROUNDS          = 64;
  localparam int NUM_BLOCK_WORDS = 16;

  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } sched_state_t;

  typedef logic [WORD_W-1:0] word_t;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational schedule expansion: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] i_w2,
  input  logic [WORD_W-1:0] i_w7,
  input  logic [WORD_W-1:0] i_w15,
  input  logic [WORD_W-1:0] i_w16,
  output logic [WORD_W-1:0] o_w
);

  logic [WORD_W-1:0] w_s0;
  logic [WORD_W-1:0] w_s1;

  assign w_s0 = sigma0(i_w15);
  assign w_s1 = sigma1(i_w2);

  // Carries out of bit 31 are dropped by the fixed-width sum.
  assign o_w = w_s1 + i_w7 + w_s0 + i_w16;

endmodule

// File: rtl/sha256_msg_schedule_ctrl.sv
// Loads one 16-word block into a circular buffer, then streams the 64-word
// SHA-256 message schedule one word per w_valid/w_ready handshake.
module sha256_msg_schedule_ctrl
  import sha256_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_word_in,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic [WORD_W-1:0] o_w_out,
  output logic [5:0]        o_w_index,
  output logic              o_w_valid,
  input  logic              i_w_ready,
  output logic              o_busy,
  output logic              o_done
);

  sched_state_t r_state;
  sched_state_t w_next_state;

  logic [3:0]        r_count;
  logic [5:0]        r_t;
  logic [WORD_W-1:0] r_buf [NUM_BLOCK_WORDS];

  logic              w_load_hs;
  logic              w_stream_hs;
  logic              w_last_load;
  logic              w_last_round;
  logic              w_expanding;
  logic [3:0]        w_slot;
  logic [WORD_W-1:0] w_expanded;
  logic [WORD_W-1:0] w_word;

  assign w_load_hs    = (r_state == LOAD) && i_word_valid;
  assign w_stream_hs  = (r_state == STREAM) && i_w_ready;
  assign w_last_load  = (r_count == 4'(NUM_BLOCK_WORDS - 1));
  assign w_last_round = (r_t == 6'(ROUNDS - 1));
  assign w_expanding  = (r_t[5:4] != 2'b00);
  assign w_slot       = r_t[3:0];

  // Slot t&15 still holds W[t-16] until it is overwritten with W[t].
  sha256_w_expand u_expand (
    .i_w2  (r_buf[w_slot - 4'd2]),
    .i_w7  (r_buf[w_slot - 4'd7]),
    .i_w15 (r_buf[w_slot - 4'd15]),
    .i_w16 (r_buf[w_slot]),
    .o_w   (w_expanded)
  );

  assign w_word    = w_expanding ? w_expanded : r_buf[w_slot];
  assign o_w_out   = (r_state == STREAM) ? w_word : '0;
  assign o_w_index = (r_state == STREAM) ? r_t : '0;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_word_ready = 1'b0;
    o_w_valid    = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = LOAD;
        end
      end
      LOAD: begin
        o_word_ready = 1'b1;
        o_busy       = 1'b1;
        if (w_load_hs && w_last_load) begin
          w_next_state = STREAM;
        end
      end
      STREAM: begin
        o_w_valid = 1'b1;
        o_busy    = 1'b1;
        if (w_stream_hs && w_last_round) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // t holds at 63 on the final handshake and only returns to 0 via DONE.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
      r_t     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_count <= '0;
            r_t     <= '0;
          end
        end
        LOAD: begin
          if (w_load_hs) begin
            r_count <= r_count + 4'd1;
          end
        end
        STREAM: begin
          if (w_stream_hs && !w_last_round) begin
            r_t <= r_t + 6'd1;
          end
        end
        DONE: begin
          r_count <= '0;
          r_t     <= '0;
        end
        default: begin
          r_count <= '0;
          r_t     <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_load_hs) begin
      r_buf[r_count] <= i_word_in;
    end else if (w_stream_hs && w_expanding) begin
      r_buf[w_slot] <= w_expanded;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule_ctrl.sv
// Scoreboard bench: expected schedules come from a plain 64-entry array model;
// a negedge monitor pops and compares on every w_valid/w_ready handshake.
module tb_sha256_msg_schedule_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] wordIn = '0;
  logic        wordValid = 1'b0;
  logic        wReady = 1'b0;
  logic        wordReady;
  logic [31:0] wOut;
  logic [5:0]  wIndex;
  logic        wValid;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] word;
    int          idx;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] modelW[64];
  logic [31:0] recv[64];
  int          recvCount = 0;
  int          doneCount = 0;
  logic [31:0] abcBlk[16];
  logic [31:0] rndBlk[16];

  sha256_msg_schedule_ctrl dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_start      (start),
    .i_word_in    (wordIn),
    .i_word_valid (wordValid),
    .o_word_ready (wordReady),
    .o_w_out      (wOut),
    .o_w_index    (wIndex),
    .o_w_valid    (wValid),
    .i_w_ready    (wReady),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] smallS0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] smallS1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic computeModel(input logic [31:0] blk[16]);
    for (int i = 0; i < 16; i++) modelW[i] = blk[i];
    for (int i = 16; i < 64; i++)
      modelW[i] = smallS1(modelW[i-2]) + modelW[i-7] + smallS0(modelW[i-15]) + modelW[i-16];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, act, req);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (done) doneCount++;
      if (wValid && wReady) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_w: got=%h idx=%0d want=none", wOut, wIndex);
        end else begin
          e = expQ.pop_front();
          checkOutput("w_out", wOut, e.word);
          checkOutput("w_index", 32'(wIndex), 32'(e.idx));
          if (recvCount < 64) recv[recvCount] = wOut;
          recvCount++;
        end
      end
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_word_ready"}, 32'(wordReady), 0);
    checkOutput({tag, "_w_valid"}, 32'(wValid), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_w_out"}, wOut, 0);
    checkOutput({tag, "_w_index"}, 32'(wIndex), 0);
  endtask

  // One full block: start, load (optionally gapped), stream (optionally stalled/aborted).
  task automatic applyStimulus(input logic [31:0] blk[16], input bit gaps, input bit randReady,
                               input int stallIdx, input int abortIdx, input bit spurious);
    int  idx;
    int  cyc;
    int  doneBase;
    bit  fin;
    bit  stalled;
    computeModel(blk);
    expQ.delete();
    for (int i = 0; i < 64; i++) expQ.push_back('{word: modelW[i], idx: i});
    recvCount = 0;
    doneBase  = doneCount;

    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;

    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 500) begin
      wordValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wordIn    = wordValid ? blk[idx] : $urandom;
      start     = spurious && ($urandom_range(0, 4) == 0);
      @(negedge clock);
      if (wordValid && wordReady) idx++;
      @(posedge clock); #1;
      cyc++;
    end
    wordValid = 1'b0;
    start     = 1'b0;
    if (idx < 16) begin
      failNow("load_timeout");
      return;
    end
    checkOutput("first_w_valid", 32'(wValid), 1);
    checkOutput("ready_after_load", 32'(wordReady), 0);

    fin = 1'b0;
    stalled = 1'b0;
    cyc = 0;
    while (!fin && cyc < 2000) begin
      if (done) begin
        fin    = 1'b1;
        start  = 1'b0;
        wReady = 1'b0;
      end else if (abortIdx >= 0 && wValid && int'(wIndex) == abortIdx) begin
        reset  = 1'b1;
        wReady = 1'b0;
        start  = 1'b0;
        #1;
        checkIdleOutputs("abort");
        expQ.delete();
        @(posedge clock); #1 reset = 1'b0;
        return;
      end else if (stallIdx >= 0 && !stalled && wValid && int'(wIndex) == stallIdx) begin
        wReady = 1'b0;
        start  = 1'b0;
        repeat (5) begin
          @(negedge clock);
          checkOutput("stall_w_out", wOut, modelW[stallIdx]);
          checkOutput("stall_w_index", 32'(wIndex), 32'(stallIdx));
          checkOutput("stall_w_valid", 32'(wValid), 1);
        end
        stalled = 1'b1;
        @(posedge clock); #1;
        cyc += 5;
      end else begin
        wReady = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
        start  = spurious && ($urandom_range(0, 7) == 0);
        @(posedge clock); #1;
        cyc++;
      end
    end
    if (!fin) begin
      failNow("stream_timeout");
      return;
    end
    @(posedge clock); #1;
    checkOutput("done_one_cycle", 32'(done), 0);
    checkOutput("busy_after_done", 32'(busy), 0);
    checkOutput("done_pulses", 32'(doneCount - doneBase), 1);
    checkOutput("handshakes", 32'(recvCount), 64);
    checkOutput("queue_empty", 32'(expQ.size()), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) abcBlk[i] = '0;
    abcBlk[0]  = 32'h61626380;
    abcBlk[15] = 32'h00000018;

    repeat (2) @(posedge clock);
    #1 checkIdleOutputs("in_reset");
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 checkIdleOutputs("idle");

    $display("[TB] abc block, w_ready held high");
    applyStimulus(abcBlk, 1'b0, 1'b0, -1, -1, 1'b0);
    checkOutput("abc_w0", recv[0], 32'h61626380);
    checkOutput("abc_w1", recv[1], 32'h00000000);
    checkOutput("abc_w15", recv[15], 32'h00000018);
    checkOutput("abc_w16", recv[16], 32'h61626380);
    checkOutput("abc_w17", recv[17], 32'h000F0000);
    checkOutput("abc_w18", recv[18], 32'h7DA86405);
    checkOutput("abc_w19", recv[19], 32'h600003C6);

    $display("[TB] backpressure at t=17");
    applyStimulus(abcBlk, 1'b0, 1'b0, 17, -1, 1'b0);
    checkOutput("bp_w17", recv[17], 32'h000F0000);

    $display("[TB] load gaps");
    applyStimulus(abcBlk, 1'b1, 1'b0, -1, -1, 1'b0);
    checkOutput("gap_w18", recv[18], 32'h7DA86405);

    $display("[TB] abort at t=30 then restart");
    applyStimulus(abcBlk, 1'b0, 1'b0, -1, 30, 1'b0);
    repeat (2) @(posedge clock);
    #1 checkIdleOutputs("after_abort");
    applyStimulus(abcBlk, 1'b0, 1'b0, -1, -1, 1'b0);
    checkOutput("restart_w0", recv[0], 32'h61626380);
    checkOutput("restart_w19", recv[19], 32'h600003C6);

    $display("[TB] spurious start pulses");
    applyStimulus(abcBlk, 1'b1, 1'b1, -1, -1, 1'b1);

    $display("[TB] random blocks");
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 16; i++) rndBlk[i] = $urandom;
      applyStimulus(rndBlk, 1'b1, 1'b1, (b == 2) ? 40 : -1, -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_msg_schedule_ctrl.md
Name: sha256_msg_schedule_ctrl

Overview:
Controller that sequences the small-sigma datapath (sigma0/sigma1) to expand one 512-bit SHA-256 block into the 64-word message schedule W[0..63].
- Accepts 16 input words serially and stores them in a 16-entry circular buffer.
- Streams W[t] one word per handshake to the round/compression logic.
- Sits between the padding/block-load path and the compression core.

Parameters:
WORD_W, 32, word width; fixed for SHA-256, not for override.
ROUNDS, 64, number of schedule words emitted per block.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins a new block; honoured only in IDLE.
word_in  input  32  message word for the load phase.
word_valid  input  1  word_in is valid during LOAD.
word_ready  output  1  block accepts word_in; high only in LOAD.
w_out  output  32  current schedule word W[t].
w_index  output  6  t of w_out, 0..63.
w_valid  output  1  w_out/w_index valid; high only in STREAM.
w_ready  input  1  consumer accepts w_out.
busy  output  1  high in LOAD or STREAM.
done  output  1  one-cycle pulse after W[63] is accepted.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE; load count=0; t=0.
  - word_ready=0, w_valid=0, busy=0, done=0.
  - w_index=0, w_out=0 (w_out is masked to 0 outside STREAM).
  - Buffer contents need no reset.
- States:
  - IDLE: start=1 -> LOAD, count=0. start outside IDLE is ignored.
  - LOAD: word_ready=1. On word_valid&&word_ready, write buf[count]=word_in and count++. On the 16th accepted word -> STREAM with t=0 in the next cycle.
  - STREAM: w_valid=1, w_index=t.
    - For t<16: w_out=buf[t].
    - For t>=16: w_out = sigma1(buf[(t-2)&15]) + buf[(t-7)&15] + sigma0(buf[(t-15)&15]) + buf[(t-16)&15], mod 2^32.
    - On w_valid&&w_ready with t>=16: buf[t&15] <= w_out.
    - Every handshake: t++. Handshake at t=63 -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x); sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Both are purely combinational.
  - Additions are 32-bit; carries out of bit 31 are discarded.
- w_out is combinational from the buffer and t. It must stay stable while w_valid=1 and w_ready=0 (backpressure). The buffer is not written without a handshake.
- Latency:
  - 16 load handshakes.
  - First w_valid appears in the cycle after the 16th load handshake.
  - With w_ready held high, one W per cycle: 64 cycles, then done.
- Boundaries:
  - word_valid low in LOAD: stall, count holds.
  - w_ready low: stall indefinitely, no state change.
  - start during LOAD/STREAM/DONE: ignored.
  - reset mid-LOAD or mid-STREAM: abort immediately; outputs go to reset values the same cycle; the partial block is discarded.
  - start in the same cycle as the DONE->IDLE transition: ignored; start is sampled only in IDLE.
  - t wraps only through the DONE->IDLE path, never 63->0 inside STREAM.

Decomposition:
- Shared package sha256_pkg:
  - WORD_W, ROUNDS, NUM_BLOCK_WORDS=16.
  - State enum {IDLE, LOAD, STREAM, DONE}.
  - Rotate amounts (7,18,3,17,19,10).
- One natural sub-module: sha256_w_expand, the combinational W[t] = s1+w7+s0+w16 adder tree using the team's sigma0/sigma1 functions. The FSM, counters and circular buffer stay in the top.

Test Plan:
- Reset then idle: assert reset mid-cycle -> all outputs 0 immediately; no word_ready until start.
- "abc" block, w_ready=1:
  - Stimulus: W0=0x61626380, W1..W14=0, W15=0x00000018.
  - Required: w_out sequence begins 0x61626380, 0,...,0x00000018.
  - Then W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6.
  - Required: exactly 64 handshakes, then done for 1 cycle.
- Backpressure: w_ready=0 for 5 cycles at t=17 -> w_out holds 0x000F0000, w_index holds 17; resumes correctly.
- Load gaps: word_valid toggled 1/0 during LOAD -> exactly 16 words captured, output identical to the gap-free run.
- Abort: reset asserted at t=30, then a new start with the "abc" block -> full correct 64-word sequence from W0.
- Spurious start: start pulses during LOAD and STREAM -> no effect on count, t or output values.
